// File: rtl/commaalign_gpi_monitor_if.sv
// Bundles the comma-align monitor's lane inputs and GPIO/status outputs.
interface commaalign_gpi_monitor_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]   rxcommaalignen_in;
  logic [NUM_CH-1:0]   clr_sticky;
  logic [15:0]         gpi_out;
  logic [NUM_CH-1:0]   sticky_out;
  logic [8*NUM_CH-1:0] rise_cnt;

  modport master (
    output rxcommaalignen_in, clr_sticky,
    input  gpi_out, sticky_out, rise_cnt
  );

  modport slave (
    input  rxcommaalignen_in, clr_sticky,
    output gpi_out, sticky_out, rise_cnt
  );
endinterface

// File: rtl/commaalign_gpi_monitor.sv
// Synchronises per-lane comma-align enables onto GPIO bits (live or stretched),
// with per-lane sticky rise flags and saturating rise counters.
module commaalign_gpi_monitor #(
  parameter int NUM_CH      = 2,
  parameter int CH_BASE     = 2,
  parameter int GPI_OFFSET  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STRETCH_EN  = 1
) (
  input logic                     clk,
  input logic                     rst,
  commaalign_gpi_monitor_if.slave mon
);

  if (NUM_CH < 1 || NUM_CH > 8 || CH_BASE < 0 || GPI_OFFSET < 0 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 255 ||
      STRETCH_EN < 0 || STRETCH_EN > 1 ||
      CH_BASE + GPI_OFFSET + NUM_CH > 16) begin : g_param_err
    $error("commaalign_gpi_monitor: illegal parameter combination");
  end

  localparam int          LSB       = CH_BASE + GPI_OFFSET;
  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACTIVE = 2'd1;
  localparam logic [1:0]  ST_HOLD   = 2'd2;

  logic [NUM_CH-1:0]   lane_out;
  logic [NUM_CH-1:0]   lane_sticky;
  logic [8*NUM_CH-1:0] lane_cnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   out_q, out_d;
    logic                   sticky_q, sticky_d;
    logic [7:0]             cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], mon.rxcommaalignen_in[i]};
        prev_q <= s;
      end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;

    if (STRETCH_EN != 0) begin : g_stretch
      logic [1:0] state_q, state_d;
      logic [7:0] hold_q, hold_d;

      // Re-assertion during HOLD takes priority over counter expiry.
      always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
          ST_IDLE:   if (s) state_d = ST_ACTIVE;
          ST_ACTIVE: if (!s) begin
                       state_d = ST_HOLD;
                       hold_d  = HOLD_LOAD;
                     end
          ST_HOLD:   if (s)                state_d = ST_ACTIVE;
                     else if (hold_q == 8'd0) state_d = ST_IDLE;
                     else                  hold_d  = hold_q - 8'd1;
          default:   state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= ST_IDLE;
          hold_q  <= 8'd0;
        end else begin
          state_q <= state_d;
          hold_q  <= hold_d;
        end
      end

      assign out_d = (state_d != ST_IDLE);
    end else begin : g_live
      assign out_d = s;
    end

    always_comb begin
      sticky_d = rise | (sticky_q & ~mon.clr_sticky[i]);
      cnt_d    = cnt_q;
      if (mon.clr_sticky[i])
        cnt_d = rise ? 8'd1 : 8'd0;
      else if (rise && cnt_q != 8'hFF)
        cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q    <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= 8'd0;
      end else begin
        out_q    <= out_d;
        sticky_q <= sticky_d;
        cnt_q    <= cnt_d;
      end
    end

    assign lane_out[i]         = out_q;
    assign lane_sticky[i]      = sticky_q;
    assign lane_cnt[8*i +: 8]  = cnt_q;
  end

  always_comb begin
    mon.gpi_out              = 16'h0000;
    mon.gpi_out[LSB +: NUM_CH] = lane_out;
  end

  assign mon.sticky_out = lane_sticky;
  assign mon.rise_cnt   = lane_cnt;

endmodule
